branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Dynamic branch predictor (BTB + 2-bit BHT) replacing static not-taken fetch with ID-stage beq resolution.
//  Looks up the IF-stage PC combinationally and supplies the predicted next PC.
//  Is trained by the ID-stage branch resolution and raises mispredict/recovery for the IF flush.
//  Sits between PC, IF/ID buffer and branch-compare logic in the 5-stage core.
// PARAMETERS
//  XLEN      32  address/data width
//  ENTRIES   16  table entries; power of 2, >=2; IDX_W=log2(ENTRIES)
//  CNT_W     2   saturating-counter width; MSB=1 means predict taken
//  CNT_INIT  1   counter value loaded at reset (weakly not-taken for CNT_W=2)
//  PERF_W    32  performance-counter width
// PORTS
//  clk_i             in   1      clock, rising edge
//  rst_i             in   1      reset, asynchronous, active-high
//  lookup_pc_i       in   XLEN   IF-stage PC
//  pred_taken_o      out  1      hit && counter MSB
//  pred_target_o     out  XLEN   predicted next PC
//  upd_valid_i       in   1      ID resolved a branch this cycle
//  upd_pc_i          in   XLEN   PC of resolved branch
//  upd_taken_i       in   1      actual outcome
//  upd_target_i      in   XLEN   actual taken target
//  upd_pred_taken_i  in   1      prediction carried with that branch
//  upd_pred_target_i in   XLEN   predicted target carried with that branch
//  clear_i           in   1      synchronous invalidate of whole table
//  mispredict_o      out  1      flush request to IF
//  recovery_pc_o     out  XLEN   correct next PC when mispredict_o=1
//  branch_cnt_o      out  PERF_W resolved branches
//  mispred_cnt_o     out  PERF_W mispredictions
// BEHAVIOUR
//  - Index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]; entry = {valid, tag, target, cnt}.
//  - Lookup is combinational, 0 cycles: hit = valid && tag match.
//    pred_target_o = (hit && cnt MSB) ? entry.target : lookup_pc_i+4 (mod 2^XLEN).
//  - mispredict_o (combinational) = upd_valid_i && ((upd_taken_i != upd_pred_taken_i) || (upd_taken_i && upd_target_i != upd_pred_target_i)).
//  - recovery_pc_o = upd_taken_i ? upd_target_i : upd_pc_i+4; it is don't-care when mispredict_o=0.
//  - Update on rising edge when upd_valid_i:
//    - Hit: cnt +1 if taken, -1 if not, saturating at 0 and 2^CNT_W-1. Target is rewritten when taken.
//    - Miss and taken: allocate (overwrite) the entry: valid=1, new tag, target, cnt = 2^(CNT_W-1) (weakly taken).
//    - Miss and not taken: no table change.
//  - Lookup and update to the same index in the same cycle: lookup returns the pre-edge contents; no bypass.
//  - clear_i clears all valid bits at the edge and wins over a simultaneous update. Counters are kept, and perf counters still count.
//  - Perf counters: branch_cnt_o +1 per upd_valid_i; mispred_cnt_o +1 per mispredict_o.
//    Both saturate at all-ones; neither wraps.
//  - Reset (async, any time incl. mid-update): all valid=0, all cnt=CNT_INIT, targets/tags=0, perf counters=0.
//    During and after reset: pred_taken_o=0, pred_target_o=lookup_pc_i+4.
//    mispredict_o follows its inputs (combinational).
//  - Out of reset, the first update is accepted on the first rising edge after rst_i falls.
// STRUCTURE
//  - Shared package cpu_pkg: CNT_W-based constants (CNT_MAX, CNT_WEAK_T), PC_STEP=4, and the entry struct/field widths.
//  - Sub-module sat_counter (combinational next-value: cnt_i, inc_i -> cnt_o, saturating), instanced in the update path.
//  - Table is flop-based (no RAM macro) so reset/clear are single-cycle.
// TESTING
//  1. Reset: assert rst_i with no clock, lookup_pc_i=0x100 -> pred_taken_o=0, pred_target_o=0x104, both perf counters=0.
//  2. Allocate/predict: update pc=0x40, taken, target=0x80, pred_taken=0 -> mispredict_o=1, recovery_pc_o=0x80.
//     Next cycle lookup 0x40 -> pred_taken_o=1, pred_target_o=0x80.
//  3. Saturation/hysteresis: on entry 0x40 apply 3 taken then 1 not-taken -> still taken.
//     A 2nd not-taken -> lookup predicts not-taken, pred_target_o=0x44.
//  4. Alias: train 0x40 taken, then taken branch at 0x80 (same index, ENTRIES=16) -> entry replaced.
//     Lookup 0x40 -> miss, pred_target_o=0x44.
//  5. Same-cycle: lookup 0x40 while updating 0x40 -> output shows old entry; new value appears next cycle.
//     clear_i with upd_valid_i -> table empty, branch_cnt_o still +1.
//  6. Perf saturation (PERF_W=4): 20 mispredicting updates -> both counters hold 15.
//     Target-only mispredict (pred T to 0x80, actual T to 0x90) -> mispredict_o=1, recovery_pc_o=0x90.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the fetch-side branch predictor.
// Latency: n/a (constants, types and elaboration-time helper functions only).
// Backpressure: n/a.
package cpu_pkg;

    // Sequential fetch advances by one 32-bit instruction.
    localparam int PC_STEP = 4;

    // Default geometry of the predictor table.
    localparam int DEF_XLEN    = 32;
    localparam int DEF_ENTRIES = 16;
    localparam int DEF_IDX_W   = $clog2(DEF_ENTRIES);
    localparam int DEF_TAG_W   = DEF_XLEN - DEF_IDX_W - 2;
    localparam int DEF_CNT_W   = 2;

    // Counter landmarks for the default counter width.
    localparam int CNT_MAX    = (1 << DEF_CNT_W) - 1;
    localparam int CNT_WEAK_T = 1 << (DEF_CNT_W - 1);

    // Counter landmarks for an arbitrary counter width.
    function automatic int cnt_max_f(input int w);
        return (1 << w) - 1;
    endfunction

    function automatic int cnt_weak_t_f(input int w);
        return 1 << (w - 1);
    endfunction

    // One table entry at the default geometry.
    typedef struct packed {
        logic                 vld;
        logic [DEF_TAG_W-1:0] tag;
        logic [DEF_XLEN-1:0]  tgt;
        logic [DEF_CNT_W-1:0] cnt;
    } bp_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter next-value logic used to train prediction counters.
// Latency: combinational, 0 cycles.
// Backpressure: none; the output follows the inputs.
module sat_counter #(
    parameter int W = 2
) (
    input  logic [W-1:0] cnt_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    // Step toward the outcome, holding at the all-ones and all-zeros rails.
    always_comb begin
        cnt_o = cnt_i;
        if (inc_i) begin
            if (cnt_i != '1) begin
                cnt_o = cnt_i + 1'b1;
            end
        end else if (cnt_i != '0) begin
            cnt_o = cnt_i - 1'b1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// BTB + 2-bit BHT: predicts the next IF PC and is trained by ID-stage branch resolution.
// Latency: lookup and mispredict/recovery are combinational; training lands on the next edge.
// Backpressure: none; one lookup and at most one update are accepted every cycle.
module branch_predictor
    import cpu_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int ENTRIES  = DEF_ENTRIES,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int CNT_INIT = 1,
    parameter int PERF_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [XLEN-1:0]   lookup_pc_i,
    output logic              pred_taken_o,
    output logic [XLEN-1:0]   pred_target_o,
    input  logic              upd_valid_i,
    input  logic [XLEN-1:0]   upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [XLEN-1:0]   upd_target_i,
    input  logic              upd_pred_taken_i,
    input  logic [XLEN-1:0]   upd_pred_target_i,
    input  logic              clear_i,
    output logic              mispredict_o,
    output logic [XLEN-1:0]   recovery_pc_o,
    output logic [PERF_W-1:0] branch_cnt_o,
    output logic [PERF_W-1:0] mispred_cnt_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    localparam logic [CNT_W-1:0] CNT_RST   = CNT_W'(CNT_INIT);
    localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_W'(cnt_weak_t_f(CNT_W));
    localparam logic [XLEN-1:0]  STEP      = XLEN'(PC_STEP);

    // Flop-based table so reset and clear complete in a single cycle.
    logic [ENTRIES-1:0] tbl_vld;
    logic [TAG_W-1:0]   tbl_tag [ENTRIES];
    logic [XLEN-1:0]    tbl_tgt [ENTRIES];
    logic [CNT_W-1:0]   tbl_cnt [ENTRIES];

    // Lookup side: word-aligned PC, low two bits carry no information.
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;

    assign lk_idx = lookup_pc_i[IDX_W+1:2];
    assign lk_tag = lookup_pc_i[XLEN-1:IDX_W+2];
    assign lk_hit = tbl_vld[lk_idx] && (tbl_tag[lk_idx] == lk_tag);

    // The reset term keeps the prediction not-taken for the whole reset window.
    assign pred_taken_o  = !rst_i && lk_hit && tbl_cnt[lk_idx][CNT_W-1];
    assign pred_target_o = pred_taken_o ? tbl_tgt[lk_idx] : lookup_pc_i + STEP;

    // Resolution side.
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [CNT_W-1:0] up_cnt_nxt;

    assign up_idx = upd_pc_i[IDX_W+1:2];
    assign up_tag = upd_pc_i[XLEN-1:IDX_W+2];
    assign up_hit = tbl_vld[up_idx] && (tbl_tag[up_idx] == up_tag);

    // A wrong direction, or a right "taken" with the wrong target, both need a flush.
    assign mispredict_o  = upd_valid_i &&
                           ((upd_taken_i != upd_pred_taken_i) ||
                            (upd_taken_i && (upd_target_i != upd_pred_target_i)));
    assign recovery_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + STEP;

    sat_counter #(
        .W (CNT_W)
    ) u_sat_counter (
        .cnt_i (tbl_cnt[up_idx]),
        .inc_i (upd_taken_i),
        .cnt_o (up_cnt_nxt)
    );

    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

    // Table training: clear beats update; a not-taken miss leaves the table alone.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tbl_vld <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_tag[i] <= '0;
                tbl_tgt[i] <= '0;
                tbl_cnt[i] <= CNT_RST;
            end
        end else if (clear_i) begin
            tbl_vld <= '0;
        end else if (upd_valid_i) begin
            if (up_hit) begin
                tbl_cnt[up_idx] <= up_cnt_nxt;
                if (upd_taken_i) begin
                    tbl_tgt[up_idx] <= upd_target_i;
                end
            end else if (upd_taken_i) begin
                tbl_vld[up_idx] <= 1'b1;
                tbl_tag[up_idx] <= up_tag;
                tbl_tgt[up_idx] <= upd_target_i;
                tbl_cnt[up_idx] <= CNT_ALLOC;
            end
        end
    end

    // Performance counters stick at all-ones instead of wrapping; clear does not stop them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            branch_cnt_o  <= '0;
            mispred_cnt_o <= '0;
        end else begin
            if (upd_valid_i && (branch_cnt_o != '1)) begin
                branch_cnt_o <= branch_cnt_o + 1'b1;
            end
            if (mispredict_o && (mispred_cnt_o != '1)) begin
                mispred_cnt_o <= mispred_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized + directed bench for branch_predictor with a queue-based scoreboard.
// Latency: expectations are issued just after a rising edge and checked on the falling edge.
// Backpressure: n/a; the monitor checks one expectation per cycle whenever one is queued.
module tb_branch_predictor;

    localparam int PERF_W = 4;
    localparam int PMAX   = (1 << PERF_W) - 1;

    logic              clk = 1'b0;
    logic              clk_en = 1'b0;
    logic              rst;
    logic [31:0]       lookup_pc;
    logic              pred_taken;
    logic [31:0]       pred_target;
    logic              upd_valid;
    logic [31:0]       upd_pc;
    logic              upd_taken;
    logic [31:0]       upd_target;
    logic              upd_pred_taken;
    logic [31:0]       upd_pred_target;
    logic              clear;
    logic              mispredict;
    logic [31:0]       recovery_pc;
    logic [PERF_W-1:0] branch_cnt;
    logic [PERF_W-1:0] mispred_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int phase    = 0;

    branch_predictor #(
        .XLEN     (32),
        .ENTRIES  (16),
        .CNT_W    (2),
        .CNT_INIT (1),
        .PERF_W   (PERF_W)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .lookup_pc_i       (lookup_pc),
        .pred_taken_o      (pred_taken),
        .pred_target_o     (pred_target),
        .upd_valid_i       (upd_valid),
        .upd_pc_i          (upd_pc),
        .upd_taken_i       (upd_taken),
        .upd_target_i      (upd_target),
        .upd_pred_taken_i  (upd_pred_taken),
        .upd_pred_target_i (upd_pred_target),
        .clear_i           (clear),
        .mispredict_o      (mispredict),
        .recovery_pc_o     (recovery_pc),
        .branch_cnt_o      (branch_cnt),
        .mispred_cnt_o     (mispred_cnt)
    );

    always #5 if (clk_en) clk = ~clk;

    // ---------------- reference model ----------------
    // Each of the 16 slots remembers which branch owns it, where it went, and a
    // confidence score 0..3 (2 and 3 mean "predict taken").
    bit          m_vld  [16];
    logic [31:0] m_tag  [16];
    logic [31:0] m_tgt  [16];
    int          m_conf [16];
    int          m_bc;
    int          m_mc;

    function automatic int slot_of(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic bit owns(input logic [31:0] pc);
        return m_vld[slot_of(pc)] && (m_tag[slot_of(pc)] == pc / 64);
    endfunction

    function automatic bit model_taken(input logic [31:0] pc);
        return owns(pc) && (m_conf[slot_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] model_target(input logic [31:0] pc);
        return model_taken(pc) ? m_tgt[slot_of(pc)] : pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_vld[i]  = 1'b0;
            m_tag[i]  = '0;
            m_tgt[i]  = '0;
            m_conf[i] = 1;
        end
        m_bc = 0;
        m_mc = 0;
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          pt;
        logic [31:0] ptg;
        bit          mp;
        logic [31:0] rpc;
        int          bc;
        int          mc;
        int          ph;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string nm, input int ph, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s (phase %0d): got %h, required %h", nm, ph, got, want);
        end
    endtask

    // Monitor: one queued expectation is compared against the DUT every falling edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pred_taken",  e.ph, {31'd0, pred_taken}, {31'd0, e.pt});
            chk("pred_target", e.ph, pred_target, e.ptg);
            chk("mispredict",  e.ph, {31'd0, mispredict}, {31'd0, e.mp});
            if (e.mp) chk("recovery_pc", e.ph, recovery_pc, e.rpc);
            chk("branch_cnt",  e.ph, 32'(branch_cnt), 32'(e.bc));
            chk("mispred_cnt", e.ph, 32'(mispred_cnt), 32'(e.mc));
        end
    end

    // One cycle of stimulus: drive, record what must be seen this cycle, then
    // advance the model to what the table holds after the coming edge.
    task automatic step(input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                        input bit ut, input logic [31:0] utg, input bit upt,
                        input logic [31:0] uptg, input bit clr);
        exp_t e;
        int   s;
        @(posedge clk);
        #1;
        lookup_pc       = lpc;
        upd_valid       = uv;
        upd_pc          = upc;
        upd_taken       = ut;
        upd_target      = utg;
        upd_pred_taken  = upt;
        upd_pred_target = uptg;
        clear           = clr;

        e.pt  = model_taken(lpc);
        e.ptg = model_target(lpc);
        e.mp  = uv && ((ut != upt) || (ut && (utg != uptg)));
        e.rpc = ut ? utg : upc + 32'd4;
        e.bc  = m_bc;
        e.mc  = m_mc;
        e.ph  = phase;
        exp_q.push_back(e);

        if (uv) m_bc = (m_bc == PMAX) ? PMAX : m_bc + 1;
        if (e.mp) m_mc = (m_mc == PMAX) ? PMAX : m_mc + 1;
        s = slot_of(upc);
        if (clr) begin
            for (int i = 0; i < 16; i++) m_vld[i] = 1'b0;
        end else if (uv) begin
            if (owns(upc)) begin
                m_conf[s] = ut ? ((m_conf[s] == 3) ? 3 : m_conf[s] + 1)
                               : ((m_conf[s] == 0) ? 0 : m_conf[s] - 1);
                if (ut) m_tgt[s] = utg;
            end else if (ut) begin
                m_vld[s]  = 1'b1;
                m_tag[s]  = upc / 64;
                m_tgt[s]  = utg;
                m_conf[s] = 2;
            end
        end
    endtask

    task automatic look(input logic [31:0] lpc);
        step(lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic upd(input logic [31:0] pc, input bit t, input logic [31:0] tg,
                       input bit pt, input logic [31:0] ptg);
        step(pc, 1'b1, pc, t, tg, pt, ptg, 1'b0);
    endtask

    // Correctly predicted update (prediction taken from the model).
    task automatic upd_ok(input logic [31:0] pc, input bit t, input logic [31:0] tg);
        upd(pc, t, tg, t, t ? tg : pc + 32'd4);
    endtask

    task automatic drain();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_pc();
        logic [31:0] pool [6] = '{32'h40, 32'h80, 32'hC0, 32'h44, 32'h1040, 32'h84};
        if ($urandom_range(0, 7) == 0) return $urandom & 32'hFFFF_FFFC;
        return pool[$urandom_range(0, 5)];
    endfunction

    function automatic logic [31:0] pick_tgt();
        logic [31:0] pool [4] = '{32'h80, 32'h90, 32'h200, 32'h300};
        return pool[$urandom_range(0, 3)];
    endfunction

    task automatic summary();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    endtask

    initial begin : watchdog
        #500000;
        n_errors++;
        $display("FAIL watchdog: got timeout, required completion");
        summary();
        $finish;
    end

    initial begin : stim
        logic [31:0] pc;
        logic [31:0] tg;
        bit          t;
        bit          pt;
        logic [31:0] ptg;

        // Reset with no clock running.
        rst             = 1'b1;
        lookup_pc       = 32'h100;
        upd_valid       = 1'b0;
        upd_pc          = 32'h40;
        upd_taken       = 1'b1;
        upd_target      = 32'h80;
        upd_pred_taken  = 1'b0;
        upd_pred_target = 32'h44;
        clear           = 1'b0;
        model_reset();
        #2;
        chk("rst_pred_taken",  0, {31'd0, pred_taken}, 32'd0);
        chk("rst_pred_target", 0, pred_target, 32'h104);
        chk("rst_branch_cnt",  0, 32'(branch_cnt), 32'd0);
        chk("rst_mispred_cnt", 0, 32'(mispred_cnt), 32'd0);
        upd_valid = 1'b1;
        #1;
        chk("rst_mispredict_comb", 0, {31'd0, mispredict}, 32'd1);
        upd_valid = 1'b0;
        clk_en    = 1'b1;
        #10;
        rst = 1'b0;

        // Allocate on a taken miss, then predict it.
        phase = 2;
        upd(32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
        look(32'h40);
        drain();
        chk("alloc_pred_target", phase, pred_target, 32'h80);

        // Hysteresis: saturate, then one not-taken keeps taken, second flips.
        phase = 3;
        repeat (3) upd_ok(32'h40, 1'b1, 32'h80);
        upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
        look(32'h40);
        upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
        look(32'h40);
        drain();
        chk("hyst_pred_target", phase, pred_target, 32'h44);

        // Alias: 0x80 shares slot 0 with 0x40 and replaces it.
        phase = 4;
        upd(32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
        upd(32'h80, 1'b1, 32'h200, 1'b0, 32'h84);
        look(32'h40);
        look(32'h80);

        // Same-cycle lookup/update sees old contents; clear beats update.
        phase = 5;
        upd(32'h80, 1'b0, 32'h0, 1'b1, 32'h200);
        look(32'h80);
        step(32'h80, 1'b1, 32'h80, 1'b1, 32'h300, 1'b0, 32'h84, 1'b1);
        look(32'h80);
        drain();
        chk("clear_miss_target", phase, pred_target, 32'h84);

        // Perf counters saturate; target-only mispredict.
        phase = 6;
        repeat (20) upd(32'h300, 1'b1, 32'h80, 1'b0, 32'h304);
        upd(32'h300, 1'b1, 32'h90, 1'b1, 32'h80);
        drain();
        chk("branch_cnt_sat",  phase, 32'(branch_cnt), 32'd15);
        chk("mispred_cnt_sat", phase, 32'(mispred_cnt), 32'd15);
        chk("tgt_only_recovery", phase, recovery_pc, 32'h90);

        // Asynchronous reset in the middle of an update.
        phase = 7;
        @(posedge clk);
        #1;
        lookup_pc      = 32'h300;
        upd_valid      = 1'b1;
        upd_pc         = 32'hC0;
        upd_taken      = 1'b1;
        upd_target     = 32'h500;
        upd_pred_taken = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_pred_taken",  phase, {31'd0, pred_taken}, 32'd0);
        chk("midrst_pred_target", phase, pred_target, 32'h304);
        chk("midrst_branch_cnt",  phase, 32'(branch_cnt), 32'd0);
        chk("midrst_mispredict",  phase, {31'd0, mispredict}, 32'd1);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        upd_valid = 1'b0;
        model_reset();
        look(32'hC0);
        look(32'h300);

        // Randomized traffic.
        phase = 8;
        for (int n = 0; n < 400; n++) begin
            pc = pick_pc();
            t  = 1'($urandom_range(0, 1));
            tg = pick_tgt();
            if ($urandom_range(0, 1) == 1) begin
                pt  = model_taken(pc);
                ptg = model_target(pc);
            end else begin
                pt  = 1'($urandom_range(0, 1));
                ptg = pick_tgt();
            end
            step(pick_pc(), ($urandom_range(0, 3) != 0), pc, t, tg, pt, ptg,
                 ($urandom_range(0, 31) == 0));
        end
        look(32'h40);

        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        summary();
        $finish;
    end

endmodule
